// File: rtl/konami_detector.sv
// konami_detector - debounced six-button Konami code recogniser with match strobe, match LED hold and error strobe
module konami_detector #(
  parameter int DEBOUNCE_CYCLES = 120000,
  parameter int TIMEOUT_CYCLES  = 12000000,
  parameter int HOLD_CYCLES     = 12000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_b,
  input  logic       btn_a,
  output logic [3:0] progress,
  output logic       match,
  output logic       match_led,
  output logic       error
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);

  localparam logic [5:0] SYM_UP    = 6'b000001;
  localparam logic [5:0] SYM_DOWN  = 6'b000010;
  localparam logic [5:0] SYM_LEFT  = 6'b000100;
  localparam logic [5:0] SYM_RIGHT = 6'b001000;
  localparam logic [5:0] SYM_B     = 6'b010000;
  localparam logic [5:0] SYM_A     = 6'b100000;

  logic [5:0]    btn_raw;
  logic [5:0]    meta_q, sync_q, deb_q, deb_prev_q, arm_q, press_q;
  logic [1:0]    vld_q;
  logic [DW-1:0] cnt_q [6];

  logic [3:0]    idx_q;
  logic [TW-1:0] tmr_q;
  logic [HW-1:0] hold_q;
  logic          match_q, led_q, error_q;

  assign btn_raw = {btn_a, btn_b, btn_right, btn_left, btn_down, btn_up};

  function automatic logic [5:0] seq_sym(input logic [3:0] idx);
    case (idx)
      4'd0, 4'd1: seq_sym = SYM_UP;
      4'd2, 4'd3: seq_sym = SYM_DOWN;
      4'd4, 4'd6: seq_sym = SYM_LEFT;
      4'd5, 4'd7: seq_sym = SYM_RIGHT;
      4'd8:       seq_sym = SYM_B;
      4'd9:       seq_sym = SYM_A;
      default:    seq_sym = 6'b000000;
    endcase
  endfunction

  // A button is armed only once it has been seen released after reset, so a
  // button held through reset cannot produce a press until it is re-pressed.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q     <= '0;
      sync_q     <= '0;
      deb_q      <= '0;
      deb_prev_q <= '0;
      arm_q      <= '0;
      press_q    <= '0;
      vld_q      <= '0;
      for (int i = 0; i < 6; i++) cnt_q[i] <= '0;
    end else begin
      meta_q     <= btn_raw;
      sync_q     <= meta_q;
      vld_q      <= {vld_q[0], 1'b1};
      deb_prev_q <= deb_q;
      press_q    <= deb_q & ~deb_prev_q & arm_q;
      for (int i = 0; i < 6; i++) begin
        if (vld_q[1] && !sync_q[i] && !deb_q[i]) arm_q[i] <= 1'b1;
        if (sync_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          deb_q[i] <= sync_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      tmr_q   <= '0;
      hold_q  <= '0;
      match_q <= 1'b0;
      led_q   <= 1'b0;
      error_q <= 1'b0;
    end else begin
      match_q <= 1'b0;
      error_q <= 1'b0;
      if (hold_q != '0) hold_q <= hold_q - HW'(1);
      led_q <= (hold_q > HW'(1));
      if (press_q != 6'b0) begin
        tmr_q <= '0;
        if (press_q == seq_sym(idx_q)) begin
          if (idx_q == 4'd9) begin
            idx_q   <= '0;
            match_q <= 1'b1;
            hold_q  <= HW'(HOLD_CYCLES);
            led_q   <= 1'b1;
          end else begin
            idx_q <= idx_q + 4'd1;
          end
        end else if (press_q == SYM_UP) begin
          // UP UP is still a valid prefix when UP breaks the run.
          idx_q   <= (idx_q == 4'd2) ? 4'd2 : 4'd1;
          error_q <= 1'b1;
        end else begin
          idx_q   <= '0;
          error_q <= 1'b1;
        end
      end else if (idx_q != 4'd0) begin
        if (tmr_q == TW'(TIMEOUT_CYCLES - 1)) begin
          idx_q   <= '0;
          error_q <= 1'b1;
          tmr_q   <= '0;
        end else begin
          tmr_q <= tmr_q + TW'(1);
        end
      end
    end
  end

  assign progress  = idx_q;
  assign match     = match_q;
  assign match_led = led_q;
  assign error     = error_q;

endmodule
